// File: rtl/saph_plr_elastic.sv
// Purpose: elastic pipeline of `latency` register stages with valid/ready handshake and flush.
// Latency: `latency` cycles from accept to first presentation at q (0 = combinational pass-through).
// Backpressure: skid=0 ready ripples combinationally from q_ready; skid=1 ready is registered per stage (one skid entry).
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   flush           - synchronous discard of every held item (data registers keep their contents)
//   d_valid/d_ready/d - upstream handshake and payload
//   q_valid/q_ready/q - downstream handshake and payload
//   count           - number of items currently held (0..latency*(1+skid))
module saph_plr_elastic #(
    parameter int width   = 1,
    parameter int latency = 1,
    parameter int skid    = 0,
    localparam int CAP    = latency * (1 + skid),
    localparam int CW     = (latency == 0) ? 1 : $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic [width-1:0] d,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [width-1:0] q,
    output logic [CW-1:0]    count
);

    generate
        if (latency == 0) begin : g_pass
            // No storage at all: the block is a wire and holds nothing.
            logic unused_pass;
            assign unused_pass = ^{clk, rst, flush};
            assign q       = d;
            assign q_valid = d_valid;
            assign d_ready = q_ready;
            assign count   = '0;
        end else begin : g_pipe
            logic          acc;
            logic          del;
            logic [CW-1:0] cnt_r;

            for (genvar k = 0; k < latency; k++) begin : stg
                // Per-stage signals are kept as separate variables so the
                // ready chain is not one self-referencing vector.
                logic             in_v;
                logic [width-1:0] in_d;
                logic             dn_rdy;
                logic             up_rdy;
                logic             v_r;
                logic [width-1:0] d_r;

                if (k == 0) begin : g_in_first
                    assign in_v = d_valid;
                    assign in_d = d;
                end else begin : g_in_chain
                    assign in_v = stg[k-1].v_r;
                    assign in_d = stg[k-1].d_r;
                end

                if (k == latency - 1) begin : g_dn_last
                    assign dn_rdy = q_ready;
                end else begin : g_dn_chain
                    assign dn_rdy = stg[k+1].up_rdy;
                end

                if (skid == 0) begin : g_plain
                    // Stage can load when empty or when its item leaves this cycle.
                    assign up_rdy = !v_r || dn_rdy;

                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            v_r <= 1'b0;
                            d_r <= '0;
                        end else if (flush) begin
                            v_r <= 1'b0;
                        end else if (up_rdy) begin
                            v_r <= in_v;
                            if (in_v) begin
                                d_r <= in_d;
                            end
                        end
                    end
                end else begin : g_skid
                    // Registered ready == "skid entry empty". Invariant: s_v implies v_r.
                    logic             s_v;
                    logic [width-1:0] s_d;
                    logic             rdy_r;
                    logic             take;
                    logic             fire;

                    assign up_rdy = rdy_r;
                    assign take   = in_v && rdy_r;
                    assign fire   = v_r && dn_rdy;

                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            v_r   <= 1'b0;
                            d_r   <= '0;
                            s_v   <= 1'b0;
                            s_d   <= '0;
                            rdy_r <= 1'b1;
                        end else if (flush) begin
                            v_r   <= 1'b0;
                            s_v   <= 1'b0;
                            rdy_r <= 1'b1;
                        end else if (s_v) begin
                            // Skid holds the younger item; move it up before taking more.
                            if (fire) begin
                                d_r   <= s_d;
                                s_v   <= 1'b0;
                                rdy_r <= 1'b1;
                            end
                        end else if (v_r && !dn_rdy) begin
                            // Main entry stalled: an arriving item parks in the skid entry.
                            if (take) begin
                                s_d   <= in_d;
                                s_v   <= 1'b1;
                                rdy_r <= 1'b0;
                            end
                        end else begin
                            v_r <= take;
                            if (take) begin
                                d_r <= in_d;
                            end
                        end
                    end
                end
            end

            assign d_ready = stg[0].up_rdy;
            assign q_valid = stg[latency-1].v_r;
            assign q       = stg[latency-1].d_r;

            assign acc = d_valid && d_ready;
            assign del = q_valid && q_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_r <= '0;
                end else if (flush) begin
                    cnt_r <= '0;
                end else if (acc && !del) begin
                    cnt_r <= cnt_r + CW'(1);
                end else if (del && !acc) begin
                    cnt_r <= cnt_r - CW'(1);
                end
            end

            assign count = cnt_r;
        end
    endgenerate

endmodule

// File: tb/tb_saph_plr_elastic.sv
`timescale 1ns/1ps
module tb_saph_plr_elastic;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // u_s: latency 3, skid 0
    logic       s_fl = 1'b0, s_dv = 1'b0, s_dr, s_qv, s_qr = 1'b0;
    logic [7:0] s_d = '0, s_q;
    logic [1:0] s_cnt;
    // u_b: latency 2, skid 1
    logic       b_fl = 1'b0, b_dv = 1'b0, b_dr, b_qv, b_qr = 1'b0;
    logic [7:0] b_d = '0, b_q;
    logic [2:0] b_cnt;
    // u_r: latency 4, skid 1
    logic       r_fl = 1'b0, r_dv = 1'b0, r_dr, r_qv, r_qr = 1'b0;
    logic [7:0] r_d = '0, r_q;
    logic [3:0] r_cnt;
    // u_p: latency 0
    logic       p_fl = 1'b0, p_dv = 1'b0, p_dr, p_qv, p_qr = 1'b0;
    logic [7:0] p_d = '0, p_q;
    logic       p_cnt;

    saph_plr_elastic #(.width(8), .latency(3), .skid(0)) u_s (
        .clk(clk), .rst(rst), .flush(s_fl), .d_valid(s_dv), .d_ready(s_dr), .d(s_d),
        .q_valid(s_qv), .q_ready(s_qr), .q(s_q), .count(s_cnt));
    saph_plr_elastic #(.width(8), .latency(2), .skid(1)) u_b (
        .clk(clk), .rst(rst), .flush(b_fl), .d_valid(b_dv), .d_ready(b_dr), .d(b_d),
        .q_valid(b_qv), .q_ready(b_qr), .q(b_q), .count(b_cnt));
    saph_plr_elastic #(.width(8), .latency(4), .skid(1)) u_r (
        .clk(clk), .rst(rst), .flush(r_fl), .d_valid(r_dv), .d_ready(r_dr), .d(r_d),
        .q_valid(r_qv), .q_ready(r_qr), .q(r_q), .count(r_cnt));
    saph_plr_elastic #(.width(8), .latency(0), .skid(1)) u_p (
        .clk(clk), .rst(rst), .flush(p_fl), .d_valid(p_dv), .d_ready(p_dr), .d(p_d),
        .q_valid(p_qv), .q_ready(p_qr), .q(p_q), .count(p_cnt));

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_q[$];
        int mcnt, sent, got, first;
        logic prev_stall;
        logic [7:0] prev_q;
        logic [7:0] pt_d [4];
        logic       pt_v [4];
        logic       pt_r [4];

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_s_qv", s_qv, 0);
        check("rst_s_dr", s_dr, 1);
        check("rst_b_dr", b_dr, 1);
        check("rst_b_cnt", b_cnt, 0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("idle_s_q", s_q, 0);
        check("idle_s_cnt", s_cnt, 0);
        check("idle_b_qv", b_qv, 0);
        check("idle_b_q", b_q, 0);

        // ---- stream: latency 3, skid 0 ----
        exp_q.delete(); sent = 0; got = 0; mcnt = 0; first = -1; s_qr = 1'b1;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            s_dv = (sent < 16);
            s_d  = 8'(sent + 1);
            #1;
            if (s_qv && first < 0) first = c;
            check("s_cnt", s_cnt, mcnt);
            if (c == 10) check("s_cnt_steady", s_cnt, 3);
            if (s_qv && s_qr) begin
                if (exp_q.size() == 0) check("s_extra", 1, 0);
                else check("s_dat", s_q, exp_q.pop_front());
                got++; mcnt--;
            end
            if (s_dv && s_dr) begin exp_q.push_back(s_d); sent++; mcnt++; end
        end
        s_dv = 1'b0;
        check("s_first", first, 3);
        check("s_delivered", got, 16);

        // ---- backpressure: latency 2, skid 1 ----
        exp_q.delete(); sent = 0; got = 0; mcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            b_qr = (c >= 11);
            b_dv = (sent < 8);
            b_d  = 8'(8'h20 + sent);
            #1;
            check("b_cnt", b_cnt, mcnt);
            if (c == 10) begin
                check("b_full_cnt", b_cnt, 4);
                check("b_full_rdy", b_dr, 0);
                check("b_full_acc", sent, 4);
            end
            if (b_qv && b_qr) begin
                if (exp_q.size() == 0) check("b_extra", 1, 0);
                else check("b_dat", b_q, exp_q.pop_front());
                got++; mcnt--;
            end
            if (b_dv && b_dr) begin exp_q.push_back(b_d); sent++; mcnt++; end
        end
        b_dv = 1'b0;
        check("b_delivered", got, 8);

        // ---- flush on a full pipeline with a concurrent offer ----
        b_qr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            b_dv = 1'b1; b_d = 8'(8'h40 + c);
        end
        @(negedge clk); #1;
        check("fl_pre_cnt", b_cnt, 4);
        b_fl = 1'b1; b_dv = 1'b1; b_d = 8'hEE;
        @(negedge clk);
        b_fl = 1'b0; b_dv = 1'b0;
        #1;
        check("fl_cnt", b_cnt, 0);
        check("fl_qv", b_qv, 0);
        check("fl_dr", b_dr, 1);
        b_qr = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            check("fl_no_out", b_qv, 0);
        end
        @(negedge clk);
        b_dv = 1'b1; b_d = 8'h55;
        @(negedge clk);
        b_dv = 1'b0;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (b_qv && b_qr) begin check("fl_next_dat", b_q, 8'h55); got++; end
            @(negedge clk);
        end
        check("fl_next_cnt", got, 1);

        // ---- asynchronous reset between edges ----
        b_qr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            b_dv = 1'b1; b_d = 8'(8'h60 + c);
        end
        @(negedge clk);
        b_dv = 1'b0;
        #1;
        check("ar_pre_cnt", b_cnt, 4);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_qv", b_qv, 0);
        check("ar_cnt", b_cnt, 0);
        check("ar_q", b_q, 0);
        check("ar_dr", b_dr, 1);
        @(negedge clk);
        rst = 1'b0; b_qr = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check("ar_no_out", b_qv, 0);
        end

        // ---- random stall: latency 4, skid 1 ----
        exp_q.delete(); mcnt = 0; prev_stall = 1'b0; prev_q = '0;
        for (int c = 0; c < 10020; c++) begin
            @(negedge clk);
            r_dv = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            r_qr = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
            r_d  = 8'($urandom);
            #1;
            check("r_cnt", r_cnt, mcnt);
            if (prev_stall) begin
                check("r_hold_v", r_qv, 1);
                check("r_hold_q", r_q, prev_q);
            end
            if (r_qv && r_qr) begin
                if (exp_q.size() == 0) check("r_extra", 1, 0);
                else check("r_dat", r_q, exp_q.pop_front());
                mcnt--;
            end
            if (r_dv && r_dr) begin exp_q.push_back(r_d); mcnt++; end
            prev_stall = r_qv && !r_qr;
            prev_q     = r_q;
        end
        check("r_left", exp_q.size(), 0);

        // ---- pass-through: latency 0 ----
        pt_d = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        pt_v = '{1'b1, 1'b1, 1'b0, 1'b0};
        pt_r = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            p_d = pt_d[i]; p_dv = pt_v[i]; p_qr = pt_r[i];
            #1;
            check("p_q", p_q, pt_d[i]);
            check("p_qv", p_qv, pt_v[i]);
            check("p_dr", p_dr, pt_r[i]);
            check("p_cnt", p_cnt, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/saph_plr_elastic.md
SAPH_PLR_ELASTIC -- requirements
Module: saph_plr_elastic

Interface
REQ-001 SHALL have parameter width, default 1, bit width of the data payload.
REQ-002 SHALL have parameter latency, default 1, number of register stages; 0 selects pass-through.
REQ-003 SHALL have parameter skid, default 0; 0 selects a combinational ready chain, 1 selects a registered ready with one skid entry per stage.
REQ-004 SHALL have port clk input 1: pipeline clock, rising edge active.
REQ-005 SHALL have port rst input 1: reset, asynchronous and active-high.
REQ-006 SHALL have port flush input 1: synchronous discard of all held items.
REQ-007 SHALL have port d_valid input 1: upstream item present.
REQ-008 SHALL have port d_ready output 1: block accepts an item this cycle.
REQ-009 SHALL have port d input width: upstream payload.
REQ-010 SHALL have port q_valid output 1: downstream item present.
REQ-011 SHALL have port q_ready input 1: downstream accepts the item.
REQ-012 SHALL have port q output width: downstream payload.
REQ-013 SHALL have port count output $clog2(cap+1), where cap = latency*(1+skid): number of items held; width is 1 when latency = 0.

Function
REQ-014 SHALL accept an item on a rising edge where d_valid && d_ready && !flush, and SHALL deliver it on a rising edge where q_valid && q_ready.
REQ-015 SHALL deliver items in order, with no loss and no duplication.
REQ-016 SHALL first present an item accepted on edge N at q in the cycle after edge N+latency-1, when no stall occurs.
REQ-017 SHALL hold q and q_valid stable while q_valid && !q_ready.
REQ-018 (skid=0) SHALL let stage k take a new item when it is empty or its item moves on in the same cycle; d_ready = !valid0 || ready1, a combinational chain from q_ready.
REQ-019 (skid=1) SHALL drive each stage's upstream ready only from a register, equal to "skid entry empty", with no combinational path from q_ready to d_ready.
REQ-020 (skid=1) SHALL put an incoming item into the stage's skid entry when it arrives while the main entry is stalled.
REQ-021 (skid=1) SHALL drain the skid entry into the main entry before accepting new items, preserving order.
REQ-022 SHALL sustain one item per cycle in both modes when full with d_valid=1 and q_ready=1.
REQ-023 SHALL, when full and q_ready=0, hold d_ready=0 within one cycle (skid=1) or combinationally (skid=0), and SHALL accept nothing.
REQ-024 SHALL update count as: +1 on accept only, -1 on deliver only, unchanged on both in the same edge; count never exceeds cap and never underflows.
REQ-025 SHALL, on an edge with flush=1, clear every valid bit and skid entry, set count to 0 and discard any concurrent d handshake; after that edge d_ready=1 and q_valid=0.
REQ-026 SHALL give flush priority over accept and deliver on the same edge.
REQ-027 SHALL leave data registers unchanged on flush; only valid state clears.
REQ-028 (latency=0) SHALL implement q=d, q_valid=d_valid, d_ready=q_ready and count=0, ignoring skid and flush.

Reset
REQ-029 SHALL, while rst=1, asynchronously force all valid bits, skid entries and count to 0, all data registers to 0, and registered ready bits to 1.
REQ-030 SHALL hold q_valid=0, q=0 and d_ready=1 during and after reset until the first accept.
REQ-031 SHALL ignore any d handshake in a cycle where rst=1.
REQ-032 SHALL, when reset is asserted mid-stream, discard all held items, with no partial output after release.

Verification
REQ-033 Stream: latency=3, skid=0, width=8, q_ready=1, send 0x01..0x10 back-to-back -> q_valid first in the cycle after the third edge, 16 items in order, count steady at 3.
REQ-034 Backpressure: latency=2, skid=1, q_ready=0 for 10 cycles with d_valid=1 -> count reaches 4 then d_ready=0; after q_ready=1, items arrive in order, none lost.
REQ-035 Random stall: latency=4, skid=1, random d_valid/q_ready for 10k cycles -> scoreboard matches and count equals the model each cycle.
REQ-036 Flush: full pipeline, flush pulse with d_valid=1 -> next cycle count=0, q_valid=0, d_ready=1; the flushed-cycle item never appears.
REQ-037 Async reset: assert rst mid-cycle between edges -> q_valid, count and q go to 0 immediately, with no clock edge needed.
REQ-038 Pass-through: latency=0 -> q tracks d and d_ready tracks q_ready in the same cycle; count=0.
